// File: rtl/count_direction_decoder_if.sv
// Sample/observation bus between a bidirectional-counter observer and its consumer.
// The observer takes the slave modport; whoever supplies Q_in/en takes the master modport.
interface count_direction_decoder_if #(
    parameter int unsigned WIDTH = 3
);
    logic [WIDTH-1:0] Q_in;
    logic             en;
    logic             mode_out;
    logic             locked;
    logic             err;
    logic             wrap;
    logic             dir_change;
    logic [15:0]      net_cnt;

    modport master (
        output Q_in,
        output en,
        input  mode_out,
        input  locked,
        input  err,
        input  wrap,
        input  dir_change,
        input  net_cnt
    );

    modport slave (
        input  Q_in,
        input  en,
        output mode_out,
        output locked,
        output err,
        output wrap,
        output dir_change,
        output net_cnt
    );
endinterface

// File: rtl/count_direction_decoder.sv
// Classifies successive samples of a remote up/down counter, recovers its direction,
// declares lock after a run of consistent steps and tracks a 16-bit net position.
module count_direction_decoder #(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                     CLK,
    input  logic                     CLR,
    count_direction_decoder_if.slave bus_io
);
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StAcq   = 2'd1;
    localparam logic [1:0] StLock  = 2'd2;

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       run_q, run_d;
    logic             run_dir_q, run_dir_d;
    logic             mode_q, mode_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic             dir_change_q, dir_change_d;
    logic [15:0]      net_q, net_d;

    logic [WIDTH-1:0] diff;
    logic             is_up, is_down, is_hold, is_step;
    logic             step_wraps;
    logic [3:0]       run_next;

    // Modular difference: +1 is an up step, all-ones is a down step.
    assign diff       = bus_io.Q_in - prev_q;
    assign is_up      = (diff == WIDTH'(1));
    assign is_down    = (diff == {WIDTH{1'b1}});
    assign is_hold    = (diff == '0);
    assign is_step    = is_up | is_down;
    assign step_wraps = (is_up && bus_io.Q_in == '0) || (is_down && bus_io.Q_in == {WIDTH{1'b1}});

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        run_dir_d    = run_dir_q;
        mode_d       = mode_q;
        locked_d     = locked_q;
        net_d        = net_q;
        err_d        = 1'b0;
        wrap_d       = 1'b0;
        dir_change_d = 1'b0;
        run_next     = run_q;

        if (bus_io.en) begin
            prev_d = bus_io.Q_in;
            if (state_q != StEmpty && is_step) begin
                net_d  = is_up ? net_q + 16'd1 : net_q - 16'd1;
                wrap_d = step_wraps;
            end

            case (state_q)
                StEmpty: begin
                    run_d   = 4'd0;
                    state_d = StAcq;
                end
                StAcq: begin
                    if (is_step) begin
                        if (run_q == 4'd0 || is_up == run_dir_q) begin
                            run_next = (run_q < LockCnt) ? run_q + 4'd1 : run_q;
                        end else begin
                            run_next = 4'd1;
                        end
                        run_d     = run_next;
                        run_dir_d = is_up;
                        if (run_next >= LockCnt) begin
                            state_d  = StLock;
                            mode_d   = is_up;
                            locked_d = 1'b1;
                        end
                    end else if (!is_hold) begin
                        err_d = 1'b1;
                        run_d = 4'd0;
                    end
                end
                StLock: begin
                    if (is_step) begin
                        if (is_up != mode_q) begin
                            dir_change_d = 1'b1;
                            mode_d       = is_up;
                            run_dir_d    = is_up;
                        end
                    end else if (!is_hold) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        run_d    = 4'd0;
                        state_d  = StAcq;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q      <= StEmpty;
            prev_q       <= '0;
            run_q        <= 4'd0;
            run_dir_q    <= 1'b0;
            mode_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
            dir_change_q <= 1'b0;
            net_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            run_dir_q    <= run_dir_d;
            mode_q       <= mode_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
            dir_change_q <= dir_change_d;
            net_q        <= net_d;
        end
    end

    assign bus_io.mode_out   = mode_q;
    assign bus_io.locked     = locked_q;
    assign bus_io.err        = err_q;
    assign bus_io.wrap       = wrap_q;
    assign bus_io.dir_change = dir_change_q;
    assign bus_io.net_cnt    = net_q;
endmodule

// File: tb/tb_count_direction_decoder.sv
// Table-driven bench for count_direction_decoder with default parameters; expected
// output tuples are queued when a vector is driven and checked after the clock edge.
module tb_count_direction_decoder;
    logic clk;
    logic clr;

    count_direction_decoder_if #(.WIDTH(3)) bus ();

    count_direction_decoder #(
        .WIDTH     (3),
        .LOCK_COUNT(4)
    ) dut (
        .CLK   (clk),
        .CLR   (clr),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp packs {mode, locked, err, wrap, dir_change, net_cnt[15:0]}
    typedef struct {
        logic        clr;
        logic        en;
        logic [2:0]  q;
        logic [20:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [20:0] exp_q[$];
    int          n_cmp;
    int          n_bad;

    function automatic vec_t v(input logic c, input logic e, input logic [2:0] q,
                               input logic m, input logic lk, input logic er,
                               input logic wr, input logic dc, input logic [15:0] net,
                               input string name);
        vec_t r;
        r.clr  = c;
        r.en   = e;
        r.q    = q;
        r.exp  = {m, lk, er, wr, dc, net};
        r.name = name;
        return r;
    endfunction

    task automatic apply(input vec_t t);
        logic [20:0] got;
        logic [20:0] want;
        @(negedge clk);
        clr     = t.clr;
        bus.en  = t.en;
        bus.Q_in = t.q;
        exp_q.push_back(t.exp);
        @(posedge clk);
        #1;
        got  = {bus.mode_out, bus.locked, bus.err, bus.wrap, bus.dir_change, bus.net_cnt};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got mode/lk/err/wrap/dc=%b net=%h, want mode/lk/err/wrap/dc=%b net=%h",
                     t.name, got[20:16], got[15:0], want[20:16], want[15:0]);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        clr      = 1'b1;
        bus.en   = 1'b0;
        bus.Q_in = 3'd0;

        // Acquisition up
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 16'd0, "reset"));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 16'd0, "empty_first"));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 16'd1, "acq_up1"));
        vecs.push_back(v(0, 1, 2, 0, 0, 0, 0, 0, 16'd2, "acq_up2"));
        vecs.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 16'd3, "acq_up3"));
        vecs.push_back(v(0, 1, 4, 1, 1, 0, 0, 0, 16'd4, "lock_up"));
        // Wrap while locked up
        vecs.push_back(v(0, 1, 5, 1, 1, 0, 0, 0, 16'd5, "lock_5"));
        vecs.push_back(v(0, 1, 6, 1, 1, 0, 0, 0, 16'd6, "lock_6"));
        vecs.push_back(v(0, 1, 7, 1, 1, 0, 0, 0, 16'd7, "lock_7"));
        vecs.push_back(v(0, 1, 0, 1, 1, 0, 1, 0, 16'd8, "wrap_up"));
        // Reversal
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, 0, 16'd9, "up_1"));
        vecs.push_back(v(0, 1, 2, 1, 1, 0, 0, 0, 16'd10, "up_2"));
        vecs.push_back(v(0, 1, 3, 1, 1, 0, 0, 0, 16'd11, "up_3"));
        vecs.push_back(v(0, 1, 2, 0, 1, 0, 0, 1, 16'd10, "reverse"));
        vecs.push_back(v(0, 1, 1, 0, 1, 0, 0, 0, 16'd9, "down_1"));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 0, 16'd8, "down_0"));
        vecs.push_back(v(0, 1, 7, 0, 1, 0, 1, 0, 16'd7, "wrap_down"));
        // Illegal jump and relock
        vecs.push_back(v(0, 1, 6, 0, 1, 0, 0, 0, 16'd6, "down_6"));
        vecs.push_back(v(0, 1, 5, 0, 1, 0, 0, 0, 16'd5, "down_5"));
        vecs.push_back(v(0, 1, 4, 0, 1, 0, 0, 0, 16'd4, "down_4"));
        vecs.push_back(v(0, 1, 3, 0, 1, 0, 0, 0, 16'd3, "down_3"));
        vecs.push_back(v(0, 1, 6, 0, 0, 1, 0, 0, 16'd3, "illegal_lock"));
        vecs.push_back(v(0, 1, 7, 0, 0, 0, 0, 0, 16'd4, "reacq_1"));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 0, 16'd5, "reacq_2_wrap"));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 16'd6, "reacq_3"));
        vecs.push_back(v(0, 1, 2, 1, 1, 0, 0, 0, 16'd7, "relock"));
        // Hold and enable gating
        vecs.push_back(v(0, 1, 2, 1, 1, 0, 0, 0, 16'd7, "hold_a"));
        vecs.push_back(v(0, 1, 2, 1, 1, 0, 0, 0, 16'd7, "hold_b"));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(v(0, 0, 3'($urandom), 1, 1, 0, 0, 0, 16'd7, "en_low"));
        end
        vecs.push_back(v(0, 1, 3, 1, 1, 0, 0, 0, 16'd8, "prev_frozen"));
        // Reset priority, then three up steps must not lock
        vecs.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 16'd0, "clr_over_en"));
        vecs.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 16'd0, "post_clr_no_err"));
        vecs.push_back(v(0, 1, 6, 0, 0, 0, 0, 0, 16'd1, "three_1"));
        vecs.push_back(v(0, 1, 7, 0, 0, 0, 0, 0, 16'd2, "three_2"));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 0, 16'd3, "three_3_wrap"));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 16'd3, "pulse_clear"));
        vecs.push_back(v(0, 1, 3, 0, 0, 1, 0, 0, 16'd3, "illegal_acq"));
        vecs.push_back(v(0, 1, 4, 0, 0, 0, 0, 0, 16'd4, "acq_b1"));
        vecs.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 16'd5, "acq_b2"));
        vecs.push_back(v(0, 1, 6, 0, 0, 0, 0, 0, 16'd6, "acq_b3"));
        vecs.push_back(v(0, 1, 7, 1, 1, 0, 0, 0, 16'd7, "acq_b_lock"));

        foreach (vecs[i]) apply(vecs[i]);

        // Net counter underflow, and a direction flip in ACQ restarting the run at 1
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 16'd0, "clr2"));
        apply(v(0, 1, 0, 0, 0, 0, 0, 0, 16'd0, "empty2"));
        apply(v(0, 1, 7, 0, 0, 0, 1, 0, 16'hFFFF, "net_underflow"));
        apply(v(0, 1, 0, 0, 0, 0, 1, 0, 16'h0000, "net_overflow_flip"));
        apply(v(0, 1, 1, 0, 0, 0, 0, 0, 16'd1, "flip_run2"));
        apply(v(0, 1, 2, 0, 0, 0, 0, 0, 16'd2, "flip_run3"));
        apply(v(0, 1, 3, 1, 1, 0, 0, 0, 16'd3, "flip_lock"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
